// File: rtl/instr_register_pkg.sv
// Shared types and default widths for the instruction register pipe.
// Latency: none (types and constants only).
// Backpressure: none.
package instr_register_pkg;

  localparam int OP_WIDTH_DEF  = 32;
  localparam int DEPTH_DEF     = 32;
  localparam int ADDR_W_DEF    = $clog2(DEPTH_DEF);
  localparam int RES_WIDTH_DEF = 2 * OP_WIDTH_DEF;

  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  // ALU result bundle at the default widths.
  typedef struct packed {
    logic signed [RES_WIDTH_DEF-1:0] result;
    logic                            div_zero;
  } alu_out_t;

  // True for the two opcodes that need a divider.
  function automatic logic is_divmod(input opcode_t op);
    return (op == DIV) || (op == MOD);
  endfunction

endpackage

// File: rtl/instr_alu.sv
// Signed ALU for the instruction register pipe; operands sign-extended to the result width.
// Latency: purely combinational.
// Backpressure: none. Divider only present when INSTR_REG_DIVMOD_EN is defined.
module instr_alu
  import instr_register_pkg::*;
#(
  parameter int OP_WIDTH  = OP_WIDTH_DEF,
  parameter int RES_WIDTH = 2 * OP_WIDTH
) (
  input  opcode_t                      opcode,
  input  logic signed [OP_WIDTH-1:0]   operand_a,
  input  logic signed [OP_WIDTH-1:0]   operand_b,
  output logic signed [RES_WIDTH-1:0]  result,
  output logic                         div_zero
);

  logic signed [RES_WIDTH-1:0] a_ext;
  logic signed [RES_WIDTH-1:0] b_ext;

  // Signed size casts sign-extend, so the product below is the exact full-width result.
  assign a_ext = RES_WIDTH'(operand_a);
  assign b_ext = RES_WIDTH'(operand_b);

  // Opcode decode; DIV/MOD with a zero divisor yield 0 and raise div_zero.
  always_comb begin
    result   = '0;
    div_zero = 1'b0;
    case (opcode)
      ZERO:  result = '0;
      PASSA: result = a_ext;
      PASSB: result = b_ext;
      ADD:   result = a_ext + b_ext;
      SUB:   result = a_ext - b_ext;
      MULT:  result = a_ext * b_ext;
      DIV, MOD: begin
`ifdef INSTR_REG_DIVMOD_EN
        div_zero = is_divmod(opcode) && (b_ext == '0);
        if (b_ext == '0) begin
          result = '0;
        end else if (opcode == DIV) begin
          result = a_ext / b_ext;
        end else begin
          result = a_ext % b_ext;
        end
`else
        result = '0;
`endif
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/instr_register_pipe.sv
// Instruction register file with 2-stage write pipeline (S1 capture, S2 ALU result), optional DIV/MOD via INSTR_REG_DIVMOD_EN.
// Latency: write commits 2 edges after capture; read data registered on the edge that samples read_en.
// Backpressure: none; one write and one read accepted every cycle, reads forward S1 > S2 > storage.
module instr_register_pipe
  import instr_register_pkg::*;
#(
  parameter int OP_WIDTH  = OP_WIDTH_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int RES_WIDTH = 2 * OP_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         load_en,
  input  opcode_t                      opcode,
  input  logic signed [OP_WIDTH-1:0]   operand_a,
  input  logic signed [OP_WIDTH-1:0]   operand_b,
  input  logic [ADDR_W-1:0]            write_pointer,
  input  logic                         read_en,
  input  logic [ADDR_W-1:0]            read_pointer,
  output logic                         rd_valid,
  output logic                         rd_hit,
  output opcode_t                      rd_opcode,
  output logic signed [OP_WIDTH-1:0]   rd_op_a,
  output logic signed [OP_WIDTH-1:0]   rd_op_b,
  output logic signed [RES_WIDTH-1:0]  rd_result,
  output logic                         rd_div_zero
);

  // S1: captured write request
  logic                        s1_vld;
  logic [ADDR_W-1:0]           s1_addr;
  opcode_t                     s1_opcode;
  logic signed [OP_WIDTH-1:0]  s1_a;
  logic signed [OP_WIDTH-1:0]  s1_b;

  // ALU output for the S1 entry
  logic signed [RES_WIDTH-1:0] alu_result;
  logic                        alu_div_zero;

  // S2: computed entry waiting to commit
  logic                        s2_vld;
  logic [ADDR_W-1:0]           s2_addr;
  opcode_t                     s2_opcode;
  logic signed [OP_WIDTH-1:0]  s2_a;
  logic signed [OP_WIDTH-1:0]  s2_b;
  logic signed [RES_WIDTH-1:0] s2_result;
  logic                        s2_div_zero;

  // Storage
  opcode_t                     mem_opcode [DEPTH];
  logic signed [OP_WIDTH-1:0]  mem_a      [DEPTH];
  logic signed [OP_WIDTH-1:0]  mem_b      [DEPTH];
  logic signed [RES_WIDTH-1:0] mem_result [DEPTH];
  logic                        mem_dz     [DEPTH];
  logic [DEPTH-1:0]            written;

  // Read selection
  logic                        sel_hit;
  opcode_t                     sel_opcode;
  logic signed [OP_WIDTH-1:0]  sel_a;
  logic signed [OP_WIDTH-1:0]  sel_b;
  logic signed [RES_WIDTH-1:0] sel_result;
  logic                        sel_dz;

  instr_alu #(
    .OP_WIDTH  (OP_WIDTH),
    .RES_WIDTH (RES_WIDTH)
  ) u_alu (
    .opcode    (s1_opcode),
    .operand_a (s1_a),
    .operand_b (s1_b),
    .result    (alu_result),
    .div_zero  (alu_div_zero)
  );

  // S1 capture of the incoming write request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld    <= 1'b0;
      s1_addr   <= '0;
      s1_opcode <= ZERO;
      s1_a      <= '0;
      s1_b      <= '0;
    end else begin
      s1_vld <= load_en;
      if (load_en) begin
        s1_addr   <= write_pointer;
        s1_opcode <= opcode;
        s1_a      <= operand_a;
        s1_b      <= operand_b;
      end
    end
  end

  // S2 register holding the ALU result of the S1 entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_vld      <= 1'b0;
      s2_addr     <= '0;
      s2_opcode   <= ZERO;
      s2_a        <= '0;
      s2_b        <= '0;
      s2_result   <= '0;
      s2_div_zero <= 1'b0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_addr     <= s1_addr;
        s2_opcode   <= s1_opcode;
        s2_a        <= s1_a;
        s2_b        <= s1_b;
        s2_result   <= alu_result;
        s2_div_zero <= alu_div_zero;
      end
    end
  end

  // Commit S2 into storage and mark the entry as written
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      written <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_opcode[i] <= ZERO;
        mem_a[i]      <= '0;
        mem_b[i]      <= '0;
        mem_result[i] <= '0;
        mem_dz[i]     <= 1'b0;
      end
    end else if (s2_vld) begin
      written[s2_addr]    <= 1'b1;
      mem_opcode[s2_addr] <= s2_opcode;
      mem_a[s2_addr]      <= s2_a;
      mem_b[s2_addr]      <= s2_b;
      mem_result[s2_addr] <= s2_result;
      mem_dz[s2_addr]     <= s2_div_zero;
    end
  end

  // Read source: youngest in-flight write wins (S1, then S2), else storage.
  // Unwritten entries read as zero because storage is cleared on reset.
  always_comb begin
    sel_hit    = written[read_pointer];
    sel_opcode = mem_opcode[read_pointer];
    sel_a      = mem_a[read_pointer];
    sel_b      = mem_b[read_pointer];
    sel_result = mem_result[read_pointer];
    sel_dz     = mem_dz[read_pointer];
    if (s2_vld && (s2_addr == read_pointer)) begin
      sel_hit    = 1'b1;
      sel_opcode = s2_opcode;
      sel_a      = s2_a;
      sel_b      = s2_b;
      sel_result = s2_result;
      sel_dz     = s2_div_zero;
    end
    if (s1_vld && (s1_addr == read_pointer)) begin
      sel_hit    = 1'b1;
      sel_opcode = s1_opcode;
      sel_a      = s1_a;
      sel_b      = s1_b;
      sel_result = alu_result;
      sel_dz     = alu_div_zero;
    end
  end

  // Registered read port; fields hold their value when no read is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid    <= 1'b0;
      rd_hit      <= 1'b0;
      rd_opcode   <= ZERO;
      rd_op_a     <= '0;
      rd_op_b     <= '0;
      rd_result   <= '0;
      rd_div_zero <= 1'b0;
    end else begin
      rd_valid <= read_en;
      if (read_en) begin
        rd_hit      <= sel_hit;
        rd_opcode   <= sel_opcode;
        rd_op_a     <= sel_a;
        rd_op_b     <= sel_b;
        rd_result   <= sel_result;
        rd_div_zero <= sel_dz;
      end
    end
  end

endmodule

// File: tb/tb_instr_register_pipe.sv
// Scoreboard bench for instr_register_pipe (DEPTH=8 so pointer wrap is exercised).
// Stimulus pushes hand-computed expected reads; a negedge monitor pops and compares on rd_valid.
// Expected DIV/MOD values follow INSTR_REG_DIVMOD_EN.
module tb_instr_register_pipe;
  import instr_register_pkg::*;

  localparam int OPW   = 32;
  localparam int DEP   = 8;
  localparam int AW    = 3;
  localparam int RESW  = 64;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    load_en;
  opcode_t                 opcode;
  logic signed [OPW-1:0]   operand_a;
  logic signed [OPW-1:0]   operand_b;
  logic [AW-1:0]           write_pointer;
  logic                    read_en;
  logic [AW-1:0]           read_pointer;
  logic                    rd_valid;
  logic                    rd_hit;
  opcode_t                 rd_opcode;
  logic signed [OPW-1:0]   rd_op_a;
  logic signed [OPW-1:0]   rd_op_b;
  logic signed [RESW-1:0]  rd_result;
  logic                    rd_div_zero;

  typedef struct {
    logic                   hit;
    opcode_t                op;
    logic signed [OPW-1:0]  a;
    logic signed [OPW-1:0]  b;
    logic signed [RESW-1:0] res;
    logic                   dz;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors    = 0;
  int   miscompares = 0;
  int   rd_idx     = 0;

  instr_register_pipe #(
    .OP_WIDTH (OPW),
    .DEPTH    (DEP)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .load_en       (load_en),
    .opcode        (opcode),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .write_pointer (write_pointer),
    .read_en       (read_en),
    .read_pointer  (read_pointer),
    .rd_valid      (rd_valid),
    .rd_hit        (rd_hit),
    .rd_opcode     (rd_opcode),
    .rd_op_a       (rd_op_a),
    .rd_op_b       (rd_op_b),
    .rd_result     (rd_result),
    .rd_div_zero   (rd_div_zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic hit, input opcode_t op, input int a, input int b,
                              input longint res, input logic dz);
    exp_t e;
    e.hit = hit; e.op = op; e.a = a; e.b = b; e.res = res; e.dz = dz;
    return e;
  endfunction

  // One clock of stimulus: optional write and optional read sampled on the same edge.
  task automatic cyc(input logic wr, input opcode_t op, input int a, input int b, input int wp,
                     input logic rd, input int rp, input exp_t e);
    load_en       = wr;
    opcode        = op;
    operand_a     = a;
    operand_b     = b;
    write_pointer = AW'(wp);
    read_en       = rd;
    read_pointer  = AW'(rp);
    if (rd) exp_q.push_back(e);
    @(posedge clk);
    #1;
    load_en = 1'b0;
    read_en = 1'b0;
  endtask

  task automatic wr_only(input opcode_t op, input int a, input int b, input int wp);
    cyc(1'b1, op, a, b, wp, 1'b0, 0, mk(0, ZERO, 0, 0, 0, 0));
  endtask

  task automatic rd_only(input int rp, input exp_t e);
    cyc(1'b0, ZERO, 0, 0, 0, 1'b1, rp, e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, ZERO, 0, 0, 0, 1'b0, 0, mk(0, ZERO, 0, 0, 0, 0));
  endtask

  task automatic check_reset_outputs(input string tag);
    vectors++;
    if (rd_valid !== 1'b0 || rd_hit !== 1'b0 || rd_opcode !== ZERO || rd_op_a !== '0 ||
        rd_op_b !== '0 || rd_result !== '0 || rd_div_zero !== 1'b0) begin
      $display("FAIL %s: got valid=%0b hit=%0b op=%0d a=%0d b=%0d res=%0d dz=%0b, expected all zero",
               tag, rd_valid, rd_hit, rd_opcode, rd_op_a, rd_op_b, rd_result, rd_div_zero);
      miscompares++;
    end
  endtask

  // Monitor: every presented read is matched against the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && rd_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_read: rd_valid=1 with no read outstanding");
        miscompares++;
      end else begin
        mon_e = exp_q.pop_front();
        if (rd_hit !== mon_e.hit || rd_opcode !== mon_e.op || rd_op_a !== mon_e.a ||
            rd_op_b !== mon_e.b || rd_result !== mon_e.res || rd_div_zero !== mon_e.dz) begin
          $display("FAIL read_%0d: got hit=%0b op=%0d a=%0d b=%0d res=%0d dz=%0b, expected hit=%0b op=%0d a=%0d b=%0d res=%0d dz=%0b",
                   rd_idx, rd_hit, rd_opcode, rd_op_a, rd_op_b, rd_result, rd_div_zero,
                   mon_e.hit, mon_e.op, mon_e.a, mon_e.b, mon_e.res, mon_e.dz);
          miscompares++;
        end
      end
      rd_idx++;
    end
  end

  initial begin
    reset_n       = 1'b0;
    load_en       = 1'b0;
    opcode        = ZERO;
    operand_a     = '0;
    operand_b     = '0;
    write_pointer = '0;
    read_en       = 1'b0;
    read_pointer  = '0;
    #1;
    check_reset_outputs("reset_state");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Populate an entry so outputs are non-zero before the mid-burst reset.
    wr_only(PASSA, 5, 0, 4);
    idle(3);
    rd_only(4, mk(1, PASSA, 5, 0, 5, 0));
    idle(1);

    // Reset asserted in the middle of a write burst to addr 3.
    wr_only(ADD, 1, 2, 3);
    wr_only(ADD, 1, 2, 3);
    load_en   = 1'b1;
    opcode    = ADD;
    operand_a = 1;
    operand_b = 2;
    write_pointer = 3'd3;
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset_clear");
    repeat (2) @(posedge clk);
    #1;
    load_en = 1'b0;
    reset_n = 1'b1;
    rd_only(3, mk(0, ZERO, 0, 0, 0, 0));
    idle(3);
    rd_only(3, mk(0, ZERO, 0, 0, 0, 0));
    rd_only(4, mk(0, ZERO, 0, 0, 0, 0));

    // ADD committed then read from storage.
    wr_only(ADD, -7, 3, 5);
    idle(3);
    rd_only(5, mk(1, ADD, -7, 3, -4, 0));

    // MULT to addr 9 (wraps to 1): same-edge read misses, then S1 and S2 forwarding, then storage.
    cyc(1'b1, MULT, 6, -5, 9, 1'b1, 9, mk(0, ZERO, 0, 0, 0, 0));
    rd_only(9, mk(1, MULT, 6, -5, -30, 0));
    rd_only(9, mk(1, MULT, 6, -5, -30, 0));
    rd_only(1, mk(1, MULT, 6, -5, -30, 0));

    // DIV/MOD cases, back-to-back writes.
    wr_only(DIV, -15, 4, 5);
    wr_only(MOD, -15, 4, 6);
    wr_only(DIV, 9, 0, 7);
    wr_only(DIV, 9, 4, 2);
    idle(3);
`ifdef INSTR_REG_DIVMOD_EN
    rd_only(5, mk(1, DIV, -15, 4, -3, 0));
    rd_only(6, mk(1, MOD, -15, 4, -3, 0));
    rd_only(7, mk(1, DIV, 9, 0, 0, 1));
    rd_only(2, mk(1, DIV, 9, 4, 2, 0));
`else
    rd_only(5, mk(1, DIV, -15, 4, 0, 0));
    rd_only(6, mk(1, MOD, -15, 4, 0, 0));
    rd_only(7, mk(1, DIV, 9, 0, 0, 0));
    rd_only(2, mk(1, DIV, 9, 4, 0, 0));
`endif

    // SUB and a full-width signed product.
    wr_only(SUB, 3, 10, 3);
    wr_only(MULT, 32'h7FFF_FFFF, -2, 4);
    idle(3);
    rd_only(3, mk(1, SUB, 3, 10, -7, 0));
    rd_only(4, mk(1, MULT, 32'h7FFF_FFFF, -2, 64'hFFFF_FFFF_0000_0002, 0));

    // Fill every entry, then pointer 8 wraps onto entry 0.
    for (int p = 0; p < 8; p++) wr_only(PASSA, p * 10, 0, p);
    wr_only(PASSA, 99, 0, 8);
    idle(3);
    for (int p = 7; p >= 1; p--) rd_only(p, mk(1, PASSA, p * 10, 0, p * 10, 0));
    rd_only(0, mk(1, PASSA, 99, 0, 99, 0));

    // Two writes to addr 2 in flight: the younger one (S1) wins, and also wins after commit.
    wr_only(PASSA, 11, 0, 2);
    wr_only(PASSB, 0, 12, 2);
    rd_only(2, mk(1, PASSB, 0, 12, 12, 0));
    idle(3);
    rd_only(2, mk(1, PASSB, 0, 12, 12, 0));

    idle(3);
    vectors++;
    if (exp_q.size() != 0) begin
      $display("FAIL reads_outstanding: got %0d unanswered reads, expected 0", exp_q.size());
      miscompares++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
